// File: rtl/connect_n_game_ctrl.sv
// connect_n_game_ctrl
//   Parametrised Connect-N game core. Holds the board, per-column fill heights,
//   cursor, turn and move counters and a per-turn countdown with forced turn pass.
//   After every drop a sequential scanner walks outward from the placed disc,
//   one board cell per cycle, to detect a win; a full board without a win is a draw.
//
// Ports
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_restart          synchronous new-game pulse, honoured in every state
//   i_move_left/right  cursor pulses (ignored when both are set)
//   i_drop             drop a disc in the cursor column
//   i_tick             1 Hz turn-timer enable
//   o_board            cell (r,c) at [2*(r*COLS+c)+:2]; 00 empty, 01 P0, 10 P1
//   o_cursor_col       selected column
//   o_player_turn      player to move
//   o_state            00 PLAY, 01 CHECK, 10 WIN, 11 DRAW
//   o_winner           00 none, 01 P0, 10 P1
//   o_time_left        ticks remaining this turn
//   o_move_count       discs placed
//   o_illegal          one-cycle pulse on a drop into a full column
//   o_timeout          one-cycle pulse when a turn is forfeited
module connect_n_game_ctrl #(
    parameter int unsigned ROWS      = 6,
    parameter int unsigned COLS      = 7,
    parameter int unsigned WIN_LEN   = 4,
    parameter int unsigned TURN_TIME = 10,
    localparam int unsigned CW       = $clog2(COLS),
    localparam int unsigned TW       = (TURN_TIME > 0) ? $clog2(TURN_TIME + 1) : 1,
    localparam int unsigned MW       = $clog2(ROWS * COLS + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_restart,
    input  logic                   i_move_left,
    input  logic                   i_move_right,
    input  logic                   i_drop,
    input  logic                   i_tick,
    output logic [2*ROWS*COLS-1:0] o_board,
    output logic [CW-1:0]          o_cursor_col,
    output logic                   o_player_turn,
    output logic [1:0]             o_state,
    output logic [1:0]             o_winner,
    output logic [TW-1:0]          o_time_left,
    output logic [MW-1:0]          o_move_count,
    output logic                   o_illegal,
    output logic                   o_timeout
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned HW    = $clog2(ROWS + 1);
    localparam int unsigned NW    = $clog2(WIN_LEN + 1);
    localparam int unsigned CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        StPlay  = 2'b00,
        StCheck = 2'b01,
        StWin   = 2'b10,
        StDraw  = 2'b11
    } state_e;

    // Architectural state
    state_e                 r_state,      w_state;
    logic [2*CELLS-1:0]     r_board,      w_board;
    logic [HW-1:0]          r_height [COLS];
    logic [HW-1:0]          w_height [COLS];
    logic [CW-1:0]          r_cursor,     w_cursor;
    logic                   r_turn,       w_turn;
    logic [1:0]             r_winner,     w_winner;
    logic [TW-1:0]          r_time_left,  w_time_left;
    logic [MW-1:0]          r_move_count, w_move_count;
    logic                   r_illegal,    w_illegal;
    logic                   r_timeout,    w_timeout;

    // Win scanner: placed disc, its code, current direction/side, run length, walker
    logic [RW-1:0]          r_prow,       w_prow;
    logic [CW-1:0]          r_pcol,       w_pcol;
    logic [1:0]             r_code,       w_code;
    logic [1:0]             r_dir,        w_dir;    // 0 horiz, 1 vert, 2 diag, 3 anti-diag
    logic                   r_side,       w_side;   // 0 walking +step, 1 walking -step
    logic [NW-1:0]          r_count,      w_count;
    logic [RW-1:0]          r_wrow,       w_wrow;
    logic [CW-1:0]          r_wcol,       w_wcol;

    logic [HW-1:0]          w_cur_height;
    logic [1:0]             w_code_now;
    int                     w_drop_idx;
    int                     w_dr;
    int                     w_dc;
    int                     w_probe_row;
    int                     w_probe_col;
    logic                   w_probe_in;
    logic [1:0]             w_probe_code;
    logic                   w_probe_hit;

    assign w_code_now = {r_turn, ~r_turn};

    // Fill height of the cursor column and the linear index of its next free cell
    always_comb begin
        w_cur_height = '0;
        for (int c = 0; c < COLS; c++) begin
            if (c == int'(r_cursor)) begin
                w_cur_height = r_height[c];
            end
        end
        w_drop_idx = int'(w_cur_height) * int'(COLS) + int'(r_cursor);
    end

    // Next cell the scanner examines: walker plus the signed step of the current side
    always_comb begin
        w_dr = 0;
        w_dc = 1;
        case (r_dir)
            2'd0:    begin w_dr = 0; w_dc = 1;  end
            2'd1:    begin w_dr = 1; w_dc = 0;  end
            2'd2:    begin w_dr = 1; w_dc = 1;  end
            default: begin w_dr = 1; w_dc = -1; end
        endcase
        if (r_side) begin
            w_dr = -w_dr;
            w_dc = -w_dc;
        end
        w_probe_row = int'(r_wrow) + w_dr;
        w_probe_col = int'(r_wcol) + w_dc;
        w_probe_in  = (w_probe_row >= 0) && (w_probe_row < int'(ROWS)) &&
                      (w_probe_col >= 0) && (w_probe_col < int'(COLS));
        w_probe_code = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (w_probe_in && (i == w_probe_row * int'(COLS) + w_probe_col)) begin
                w_probe_code = r_board[2*i +: 2];
            end
        end
        w_probe_hit = w_probe_in && (w_probe_code == r_code);
    end

    // Next-state logic
    always_comb begin
        w_state      = r_state;
        w_board      = r_board;
        w_height     = r_height;
        w_cursor     = r_cursor;
        w_turn       = r_turn;
        w_winner     = r_winner;
        w_time_left  = r_time_left;
        w_move_count = r_move_count;
        w_illegal    = 1'b0;
        w_timeout    = 1'b0;
        w_prow       = r_prow;
        w_pcol       = r_pcol;
        w_code       = r_code;
        w_dir        = r_dir;
        w_side       = r_side;
        w_count      = r_count;
        w_wrow       = r_wrow;
        w_wcol       = r_wcol;

        if (i_restart) begin
            w_state      = StPlay;
            w_board      = '0;
            for (int c = 0; c < COLS; c++) begin
                w_height[c] = '0;
            end
            w_cursor     = '0;
            w_turn       = 1'b0;
            w_winner     = '0;
            w_time_left  = TW'(TURN_TIME);
            w_move_count = '0;
        end else begin
            case (r_state)
                StPlay: begin
                    if (i_drop && (int'(w_cur_height) < int'(ROWS))) begin
                        // Legal drop wins over moves and swallows a coincident tick
                        for (int i = 0; i < CELLS; i++) begin
                            if (i == w_drop_idx) begin
                                w_board[2*i +: 2] = w_code_now;
                            end
                        end
                        for (int c = 0; c < COLS; c++) begin
                            if (c == int'(r_cursor)) begin
                                w_height[c] = r_height[c] + HW'(1);
                            end
                        end
                        w_move_count = r_move_count + MW'(1);
                        w_prow       = RW'(w_cur_height);
                        w_pcol       = r_cursor;
                        w_wrow       = RW'(w_cur_height);
                        w_wcol       = r_cursor;
                        w_code       = w_code_now;
                        w_dir        = 2'd0;
                        w_side       = 1'b0;
                        w_count      = NW'(1);
                        w_state      = StCheck;
                    end else begin
                        if (i_drop) begin
                            w_illegal = 1'b1;
                        end else if (i_move_left && !i_move_right) begin
                            w_cursor = (r_cursor == '0) ? CW'(COLS - 1) : r_cursor - CW'(1);
                        end else if (i_move_right && !i_move_left) begin
                            w_cursor = (r_cursor == CW'(COLS - 1)) ? '0 : r_cursor + CW'(1);
                        end
                        if ((TURN_TIME > 0) && i_tick) begin
                            if (r_time_left == TW'(1)) begin
                                w_timeout   = 1'b1;
                                w_turn      = ~r_turn;
                                w_time_left = TW'(TURN_TIME);
                            end else begin
                                w_time_left = r_time_left - TW'(1);
                            end
                        end
                    end
                end

                StCheck: begin
                    if (w_probe_hit) begin
                        if (int'(r_count) + 1 >= int'(WIN_LEN)) begin
                            w_state  = StWin;
                            w_winner = r_code;
                        end else begin
                            w_count = r_count + NW'(1);
                            w_wrow  = RW'(w_probe_row);
                            w_wcol  = CW'(w_probe_col);
                        end
                    end else if (!r_side) begin
                        // Positive run ended; walk the other way keeping the count
                        w_side = 1'b1;
                        w_wrow = r_prow;
                        w_wcol = r_pcol;
                    end else if (r_dir != 2'd3) begin
                        w_dir   = r_dir + 2'd1;
                        w_side  = 1'b0;
                        w_count = NW'(1);
                        w_wrow  = r_prow;
                        w_wcol  = r_pcol;
                    end else if (r_move_count == MW'(CELLS)) begin
                        w_state = StDraw;
                    end else begin
                        w_state     = StPlay;
                        w_turn      = ~r_turn;
                        w_time_left = TW'(TURN_TIME);
                    end
                end

                default: begin
                    // WIN and DRAW hold until restart
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StPlay;
            r_board      <= '0;
            for (int c = 0; c < COLS; c++) begin
                r_height[c] <= '0;
            end
            r_cursor     <= '0;
            r_turn       <= 1'b0;
            r_winner     <= '0;
            r_time_left  <= TW'(TURN_TIME);
            r_move_count <= '0;
            r_illegal    <= 1'b0;
            r_timeout    <= 1'b0;
            r_prow       <= '0;
            r_pcol       <= '0;
            r_code       <= '0;
            r_dir        <= '0;
            r_side       <= 1'b0;
            r_count      <= '0;
            r_wrow       <= '0;
            r_wcol       <= '0;
        end else begin
            r_state      <= w_state;
            r_board      <= w_board;
            r_height     <= w_height;
            r_cursor     <= w_cursor;
            r_turn       <= w_turn;
            r_winner     <= w_winner;
            r_time_left  <= w_time_left;
            r_move_count <= w_move_count;
            r_illegal    <= w_illegal;
            r_timeout    <= w_timeout;
            r_prow       <= w_prow;
            r_pcol       <= w_pcol;
            r_code       <= w_code;
            r_dir        <= w_dir;
            r_side       <= w_side;
            r_count      <= w_count;
            r_wrow       <= w_wrow;
            r_wcol       <= w_wcol;
        end
    end

    assign o_board       = r_board;
    assign o_cursor_col  = r_cursor;
    assign o_player_turn = r_turn;
    assign o_state       = r_state;
    assign o_winner      = r_winner;
    assign o_time_left   = r_time_left;
    assign o_move_count  = r_move_count;
    assign o_illegal     = r_illegal;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_connect_n_game_ctrl.sv
// Bench for connect_n_game_ctrl: a 6x7 / win 4 / timer 3 instance checked against a
// move-level game model, plus a 2x2 / win 3 / no-timer instance for full-column and draw.
module tb_connect_n_game_ctrl;

    localparam int R   = 6;
    localparam int C   = 7;
    localparam int W   = 4;
    localparam int TT  = 3;
    localparam int LAT = 8 * (W - 1) + 2;
    localparam int SLAT = 8 * (3 - 1) + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, restart, move_left, move_right, drop, tick;

    logic [2*R*C-1:0]          o_board;
    logic [$clog2(C)-1:0]      o_cursor_col;
    logic                      o_player_turn;
    logic [1:0]                o_state;
    logic [1:0]                o_winner;
    logic [$clog2(TT+1)-1:0]   o_time_left;
    logic [$clog2(R*C+1)-1:0]  o_move_count;
    logic                      o_illegal;
    logic                      o_timeout;

    logic [7:0] s_board;
    logic       s_cursor_col;
    logic       s_player_turn;
    logic [1:0] s_state;
    logic [1:0] s_winner;
    logic       s_time_left;
    logic [2:0] s_move_count;
    logic       s_illegal;
    logic       s_timeout;

    connect_n_game_ctrl #(.ROWS(R), .COLS(C), .WIN_LEN(W), .TURN_TIME(TT)) u_dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_restart(restart),
        .i_move_left(move_left), .i_move_right(move_right), .i_drop(drop), .i_tick(tick),
        .o_board(o_board), .o_cursor_col(o_cursor_col), .o_player_turn(o_player_turn),
        .o_state(o_state), .o_winner(o_winner), .o_time_left(o_time_left),
        .o_move_count(o_move_count), .o_illegal(o_illegal), .o_timeout(o_timeout)
    );

    connect_n_game_ctrl #(.ROWS(2), .COLS(2), .WIN_LEN(3), .TURN_TIME(0)) u_small (
        .i_clk(clk), .i_reset_n(reset_n), .i_restart(restart),
        .i_move_left(move_left), .i_move_right(move_right), .i_drop(drop), .i_tick(tick),
        .o_board(s_board), .o_cursor_col(s_cursor_col), .o_player_turn(s_player_turn),
        .o_state(s_state), .o_winner(s_winner), .o_time_left(s_time_left),
        .o_move_count(s_move_count), .o_illegal(s_illegal), .o_timeout(s_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Game model for the 6x7 instance
    int mb [R][C];
    int mh [C];
    int mcur, mturn, mstate, mwin, mtl, mmc, mill, mto;
    int p_state, p_win;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) mb[r][c] = 0;
        for (int c = 0; c < C; c++) mh[c] = 0;
        mcur = 0; mturn = 0; mstate = 0; mwin = 0; mtl = TT; mmc = 0; mill = 0; mto = 0;
    endfunction

    // Longest line through (r,c) in any of the four directions reaches W
    function automatic bit model_win(input int r, input int c, input int code);
        for (int d = 0; d < 4; d++) begin
            int dr;
            int dc;
            int n;
            dr = (d == 0) ? 0 : 1;
            dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
            n = 1;
            for (int s = -1; s <= 1; s += 2) begin
                int rr;
                int cc;
                rr = r + s * dr;
                cc = c + s * dc;
                while (rr >= 0 && rr < R && cc >= 0 && cc < C && mb[rr][cc] == code) begin
                    n++;
                    rr += s * dr;
                    cc += s * dc;
                end
            end
            if (n >= W) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_step(input bit rs, input bit l, input bit r, input bit d,
                                       input bit t);
        mill = 0;
        mto  = 0;
        if (rs) begin
            model_reset();
        end else if (mstate == 0) begin
            if (d && mh[mcur] < R) begin
                int row;
                int code;
                row  = mh[mcur];
                code = mturn + 1;
                mb[row][mcur] = code;
                mh[mcur]++;
                mmc++;
                mstate = 1;
                if (model_win(row, mcur, code)) begin
                    p_state = 2;
                    p_win   = code;
                end else if (mmc == R * C) begin
                    p_state = 3;
                end else begin
                    p_state = 0;
                end
            end else begin
                if (d) mill = 1;
                else if (l && !r) mcur = (mcur + C - 1) % C;
                else if (r && !l) mcur = (mcur + 1) % C;
                if (TT > 0 && t) begin
                    if (mtl == 1) begin
                        mto = 1;
                        mturn ^= 1;
                        mtl = TT;
                    end else begin
                        mtl--;
                    end
                end
            end
        end
    endfunction

    function automatic logic [2*R*C-1:0] model_board();
        logic [2*R*C-1:0] b;
        b = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                b[2*(r*C+c) +: 2] = 2'(mb[r][c]);
        return b;
    endfunction

    task automatic check_main(input string nm);
        chk({nm, ".board"},   o_board,       model_board());
        chk({nm, ".cursor"},  o_cursor_col,  mcur);
        chk({nm, ".turn"},    o_player_turn, mturn);
        chk({nm, ".state"},   o_state,       mstate);
        chk({nm, ".winner"},  o_winner,      mwin);
        chk({nm, ".time"},    o_time_left,   mtl);
        chk({nm, ".moves"},   o_move_count,  mmc);
        chk({nm, ".illegal"}, o_illegal,     mill);
        chk({nm, ".timeout"}, o_timeout,     mto);
    endtask

    // Called at a negedge; inputs live for exactly one posedge
    task automatic cycle(input bit rs, input bit l, input bit r, input bit d, input bit t);
        restart = rs; move_left = l; move_right = r; drop = d; tick = t;
        model_step(rs, l, r, d, t);
        @(negedge clk);
        restart = 0; move_left = 0; move_right = 0; drop = 0; tick = 0;
    endtask

    // Let the main DUT finish its scan while poking it with ignored inputs
    task automatic settle(input string nm);
        int j;
        j = 0;
        while (o_state == 2'b01 && j < LAT) begin
            move_left  = 1'($urandom_range(0, 1));
            move_right = 1'($urandom_range(0, 1));
            drop       = 1'($urandom_range(0, 1));
            tick       = 1'($urandom_range(0, 1));
            @(negedge clk);
            j++;
        end
        move_left = 0; move_right = 0; drop = 0; tick = 0;
        chk({nm, ".check_done"}, o_state != 2'b01, 1);
        mstate = p_state;
        if (p_state == 2) mwin = p_win;
        if (p_state == 0) begin
            mturn ^= 1;
            mtl = TT;
        end
        check_main(nm);
    endtask

    task automatic play_col(input int col, input string nm);
        int n;
        n = (col - mcur + C) % C;
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 1, 0, 0);
            check_main({nm, ".move"});
        end
        cycle(0, 0, 0, 1, 0);
        check_main({nm, ".drop"});
        if (mstate == 1) settle(nm);
    endtask

    task automatic spulse(input bit r, input bit d, input bit t);
        move_right = r; drop = d; tick = t;
        @(negedge clk);
        move_right = 0; drop = 0; tick = 0;
    endtask

    task automatic swait(input string nm);
        int j;
        j = 0;
        while (s_state == 2'b01 && j < SLAT) begin
            @(negedge clk);
            j++;
        end
        chk({nm, ".check_done"}, s_state != 2'b01, 1);
    endtask

    typedef struct {
        bit l, r, d, t;
        int cur, turn, st, win, mc, tl;
    } vec_t;

    vec_t vecs [22];
    int   seq_win [12];
    int   seq_miss [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //        l  r  d  t  cur turn st win mc tl
        vecs[0]  = '{1, 0, 0, 0, 6, 0, 0, 0, 0, 3};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 3};
        vecs[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 3};
        vecs[3]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 3};
        vecs[4]  = '{0, 1, 0, 0, 2, 0, 0, 0, 0, 3};
        vecs[5]  = '{0, 1, 0, 0, 3, 0, 0, 0, 0, 3};
        vecs[6]  = '{0, 0, 0, 1, 3, 0, 0, 0, 0, 2};
        vecs[7]  = '{0, 0, 1, 0, 3, 1, 0, 0, 1, 3};
        vecs[8]  = '{0, 1, 0, 0, 4, 1, 0, 0, 1, 3};
        vecs[9]  = '{0, 0, 1, 0, 4, 0, 0, 0, 2, 3};
        vecs[10] = '{1, 0, 0, 0, 3, 0, 0, 0, 2, 3};
        vecs[11] = '{0, 0, 1, 0, 3, 1, 0, 0, 3, 3};
        vecs[12] = '{0, 1, 0, 0, 4, 1, 0, 0, 3, 3};
        vecs[13] = '{0, 0, 1, 0, 4, 0, 0, 0, 4, 3};
        vecs[14] = '{1, 0, 0, 0, 3, 0, 0, 0, 4, 3};
        vecs[15] = '{0, 0, 1, 0, 3, 1, 0, 0, 5, 3};
        vecs[16] = '{0, 1, 0, 0, 4, 1, 0, 0, 5, 3};
        vecs[17] = '{0, 0, 1, 0, 4, 0, 0, 0, 6, 3};
        vecs[18] = '{1, 0, 0, 0, 3, 0, 0, 0, 6, 3};
        vecs[19] = '{0, 0, 1, 0, 3, 0, 2, 1, 7, 3};
        vecs[20] = '{0, 0, 1, 0, 3, 0, 2, 1, 7, 3};
        vecs[21] = '{1, 0, 0, 1, 3, 0, 2, 1, 7, 3};
        seq_win  = '{0, 1, 2, 2, 1, 1, 0, 0, 6, 0, 5, 3};
        seq_miss = '{0, 1, 2, 2, 1, 1, 0, 0, 6, 4, 5, 3};

        reset_n = 0; restart = 0; move_left = 0; move_right = 0; drop = 0; tick = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_main("reset");
        chk("reset.small_state", s_state, 0);
        reset_n = 1;
        @(negedge clk);

        // Vertical win from the vector table
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            cycle(0, vecs[i].l, vecs[i].r, vecs[i].d, vecs[i].t);
            if (mstate == 1) settle(nm);
            chk({nm, ".t_cursor"}, o_cursor_col,  vecs[i].cur);
            chk({nm, ".t_turn"},   o_player_turn, vecs[i].turn);
            chk({nm, ".t_state"},  o_state,       vecs[i].st);
            chk({nm, ".t_winner"}, o_winner,      vecs[i].win);
            chk({nm, ".t_moves"},  o_move_count,  vecs[i].mc);
            chk({nm, ".t_time"},   o_time_left,   vecs[i].tl);
        end

        // Anti-diagonal win for P1 ending at (0,3), then the same minus one disc
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) play_col(seq_win[i], $sformatf("adiag%0d", i));
        chk("adiag.state", o_state, 2'b10);
        chk("adiag.winner", o_winner, 2'b10);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) play_col(seq_miss[i], $sformatf("miss%0d", i));
        chk("miss.state", o_state, 2'b00);
        chk("miss.turn", o_player_turn, 1'b0);
        chk("miss.moves", o_move_count, 12);

        // Timeout and drop-with-tick
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1); check_main("to1"); chk("to1.time", o_time_left, 2);
        cycle(0, 0, 0, 0, 1); check_main("to2"); chk("to2.time", o_time_left, 1);
        cycle(0, 0, 0, 0, 1); check_main("to3");
        chk("to3.pulse", o_timeout, 1); chk("to3.turn", o_player_turn, 1);
        chk("to3.time", o_time_left, 3);
        cycle(0, 0, 0, 0, 0); chk("to4.pulse_end", o_timeout, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1); chk("to5.time", o_time_left, 1);
        cycle(0, 0, 0, 1, 1); check_main("dtick");
        chk("dtick.state", o_state, 2'b01); chk("dtick.no_timeout", o_timeout, 0);
        settle("dtick");
        chk("dtick.turn", o_player_turn, 0); chk("dtick.time", o_time_left, 3);

        // Restart two cycles after a drop aborts the scan
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rmid.in_check", o_state, 2'b01);
        cycle(1, 0, 0, 0, 0);
        check_main("rmid");
        chk("rmid.board", o_board, 0);

        // Asynchronous reset during PLAY
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        settle("pre_areset");
        cycle(0, 0, 0, 0, 1);
        #2 reset_n = 0;
        #1;
        model_reset();
        check_main("areset");
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Small board: full column, then draw
        cycle(1, 0, 0, 0, 0);
        spulse(0, 1, 0); swait("s1");
        chk("s1.board", s_board, 8'h01); chk("s1.turn", s_player_turn, 1);
        spulse(0, 1, 0); swait("s2");
        chk("s2.board", s_board, 8'h21); chk("s2.moves", s_move_count, 2);
        spulse(0, 1, 0);
        chk("sfull.illegal", s_illegal, 1); chk("sfull.board", s_board, 8'h21);
        chk("sfull.moves", s_move_count, 2); chk("sfull.turn", s_player_turn, 0);
        chk("sfull.state", s_state, 0);
        spulse(0, 0, 1);
        chk("sfull.pulse_end", s_illegal, 0); chk("s.no_timer", s_time_left, 0);
        spulse(1, 0, 0); chk("s.cursor", s_cursor_col, 1);
        spulse(0, 1, 0); swait("s3");
        chk("s3.board", s_board, 8'h25); chk("s3.moves", s_move_count, 3);
        spulse(0, 1, 0); swait("s4");
        chk("sdraw.state", s_state, 2'b11); chk("sdraw.winner", s_winner, 0);
        chk("sdraw.moves", s_move_count, 4); chk("sdraw.board", s_board, 8'hA5);
        spulse(0, 1, 0);
        chk("sdraw.hold_state", s_state, 2'b11); chk("sdraw.hold_moves", s_move_count, 4);
        chk("sdraw.no_illegal", s_illegal, 0);

        // Random play against the model
        cycle(1, 0, 0, 0, 0);
        check_main("rand_start");
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            rs = ($urandom_range(0, 299) == 0);
            if (mstate >= 2 && $urandom_range(0, 5) == 0) rs = 1;
            cycle(rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
            check_main("rand");
            if (mstate == 1) settle("rand_chk");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/connect_n_game_ctrl.md
Name: connect_n_game_ctrl

Overview:
Parametrised Connect-N game core that generalises the fixed 6x7 Connect-4 controller to any board size and win length.
- Owns the board, per-column fill heights, the cursor, turn and move counters, and a per-turn countdown with forced turn pass.
- Runs a sequential win checker that starts at the last placed disc, with draw detection.
- Sits between the button edge-detect logic and the VGA tile renderer / 7-segment drivers.
- All inputs are single-cycle pulses already synchronised to clk.

Parameters:
- ROWS, 6, board rows; row 0 is the bottom row. Range 2..16.
- COLS, 7, board columns. Range 2..16.
- WIN_LEN, 4, contiguous discs needed to win. Range 2..max(ROWS,COLS).
- TURN_TIME, 10, ticks allowed per turn; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous new-game pulse, honoured in every state.
- move_left  in  1  cursor-left pulse.
- move_right  in  1  cursor-right pulse.
- drop  in  1  drop a disc in the cursor column.
- tick  in  1  1 Hz timer enable pulse.
- board  out  2*ROWS*COLS  cell (r,c) is at bits [2*(r*COLS+c)+:2]. Encoding: 00 empty, 01 player 0, 10 player 1.
- cursor_col  out  $clog2(COLS)  selected column.
- player_turn  out  1  player to move.
- state  out  2  00 PLAY, 01 CHECK, 10 WIN, 11 DRAW.
- winner  out  2  00 none, 01 player 0, 10 player 1.
- time_left  out  $clog2(TURN_TIME+1) (min 1)  ticks remaining this turn.
- move_count  out  $clog2(ROWS*COLS+1)  discs placed.
- illegal  out  1  one-cycle pulse when a drop targets a full column.
- timeout  out  1  one-cycle pulse when a turn is forfeited.

Behaviour:
- Reset (reset_n low, asynchronous) and restart (synchronous) force the same values:
  - board all 00, heights 0, cursor_col 0, player_turn 0, state PLAY;
  - winner 00, time_left TURN_TIME, move_count 0, illegal 0, timeout 0.
- Restart wins over every other input and aborts CHECK mid-scan.
- PLAY, priority order drop > move:
  - drop with height[cursor] < ROWS: write code (player_turn+1) to cell (height, cursor) on this edge; height += 1; move_count += 1; latch the placed row/col; go to CHECK next cycle.
  - drop on a full column: illegal=1 for one cycle, no state change, timer keeps running.
  - move_left with move_right in the same cycle: ignored.
  - move_left alone: cursor decrements, wrapping 0 -> COLS-1.
  - move_right alone: cursor increments, wrapping COLS-1 -> 0.
- Timer, PLAY only and only when TURN_TIME>0:
  - tick decrements time_left.
  - tick while time_left==1: timeout=1, player_turn flips, time_left reloads to TURN_TIME, no disc placed.
  - drop together with tick: the drop is taken and the tick is discarded.
- CHECK (win scan), one board cell examined per cycle:
  - Directions in order: horizontal, vertical, diagonal (+1,+1), anti-diagonal (+1,-1).
  - Each direction starts with count=1. Walk the positive side until the cell does not match the placed code or the board edge is reached, then walk the negative side the same way.
  - count==WIN_LEN at any step: go to WIN next cycle and set winner = placed code.
  - Latency from drop to WIN/DRAW/PLAY is at most 8*(WIN_LEN-1)+2 cycles.
  - Inputs other than restart are ignored in CHECK.
- End of CHECK with no win:
  - move_count==ROWS*COLS: go to DRAW.
  - otherwise: flip player_turn, reload time_left, return to PLAY. cursor_col is kept.
- WIN and DRAW hold until restart; all other inputs are ignored.
- Outputs are registered; board reflects the new disc on the cycle after the drop edge.

Test Plan:
- Vertical win, defaults: P0 drops col 3, P1 col 4, repeated; P0's 4th drop in col 3 -> state WIN, winner 01, move_count 7, within 26 cycles of the drop.
- Horizontal/diagonal win, ROWS=6 COLS=7 WIN_LEN=4: build a P1 anti-diagonal ending at (0,3) -> WIN, winner 10. One fewer disc -> returns to PLAY with player_turn toggled.
- Full column: ROWS=2, two drops in col 0, then a third -> illegal pulse for 1 cycle, board/move_count unchanged, player_turn unchanged.
- Timeout, TURN_TIME=3: three ticks, no drop -> timeout pulse, player_turn 0->1, time_left back to 3. A drop coincident with the third tick -> drop taken, no timeout.
- Draw, ROWS=2 COLS=2 WIN_LEN=3: four legal drops -> DRAW, winner 00, move_count 4. Further drops are ignored.
- Restart mid-CHECK: pulse restart 2 cycles after a drop -> all reset values next cycle. Assert reset_n low asynchronously during PLAY -> outputs reset immediately.
